adc_readout_mux: RTL and testbench
==================================

# adc_readout_mux

Parametrised ADC readout multiplexer for the CFEB data path. It takes one parallel set of NADC ADC samples per capture strobe and serialises them one word per clock onto the output bus. It accumulates a CRC-16 over the payload and, on request, appends an L1A word, status words and a CRC word. It also detects sample sets that arrive while the serialiser is busy (overlap) and supports a direct data-load mode.

## Interface
- NADC, 6, number of ADC channels per sample set (1..16)
- ADC_W, 13, width of each ADC sample
- OUT_W, 16, output word width; must be at least max(ADC_W+1, 16)
- L1A_W, 6, width of the L1A number; must be at most OUT_W-2
- STAT_W, 24, width of the status vector; emitted as NSTAT = ceil(STAT_W/(OUT_W-2)) words

- CLK  in  1  single clock (25 ns); all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- ADC_VLD  in  1  one-cycle strobe: capture ADC now
- ADC  in  NADC*ADC_W  packed samples, channel 0 in bits [ADC_W-1:0]
- END_REQ  in  1  one-cycle strobe: emit trailer
- DLOAD  in  1  data-load mode qualifier
- DATA  in  OUT_W  data-load word
- L1A  in  L1A_W  L1A number, sampled when the trailer starts
- STATUS  in  STAT_W  status vector, sampled when the trailer starts
- OUT  out  OUT_W  output word; 0 whenever OUT_VLD is low
- OUT_VLD  out  1  OUT carries a word
- OUT_LAST  out  1  high with the CRC word only
- OVERLAP  out  1  sticky overlap flag
- BUSY  out  1  state is not IDLE

## Operation
- States: IDLE, SHIFT, TR_L1A, TR_STAT, TR_CRC.
- Reset values: all outputs 0, state IDLE, CRC 0x0000, END pending 0, channel index 0.
- IDLE + ADC_VLD:
  - latch all NADC samples and enter SHIFT.
  - SHIFT emits channel 0..NADC-1, one word per cycle.
  - Sample word: bit OUT_W-1 = OVERLAP, middle bits 0, low ADC_W bits = sample.
- Back-to-back capture:
  - ADC_VLD is also accepted on the last SHIFT cycle (channel NADC-1).
  - The new set then starts with no gap.
- Overlap:
  - ADC_VLD in any other non-IDLE cycle drops that set.
  - OVERLAP sets on the next edge and stays high until the CRC word has been emitted.
- END_REQ:
  - In IDLE: go to TR_L1A.
  - In SHIFT: latch END pending; the trailer starts after the last sample word.
  - Pending END has priority over a back-to-back ADC_VLD; that ADC_VLD counts as an overlap.
  - In a trailer state: ignored.
  - END_REQ and ADC_VLD together in IDLE: capture the set, latch END pending.
- Trailer words:
  - TR_L1A: {2'b11, zeros, L1A}.
  - TR_STAT: NSTAT words {2'b10, chunk}, low chunk first; the last chunk is zero-padded.
  - TR_CRC: {zeros, CRC16}. OUT_LAST is high with this word. CRC then resets to 0, OVERLAP clears, state returns to IDLE.
- Data-load mode:
  - In IDLE with DLOAD high, each cycle emits DATA unchanged on the next cycle and includes it in the CRC.
  - DLOAD is ignored outside IDLE.
  - ADC_VLD has priority over DLOAD in the same cycle.
- CRC rules:
  - CRC-16, polynomial 0x8005, init 0x0000, MSB first, not reflected, no final XOR.
  - One OUT_W-bit word is folded in per cycle.
  - Covered: sample and data-load words only. Trailer words are not covered.

## Timing
- All outputs are registered.
- Latency: ADC_VLD at edge n gives channel 0 on OUT at edge n+1 and channel NADC-1 at edge n+NADC.
- Trailer after END_REQ in IDLE at edge n:
  - L1A word at n+1.
  - Status words at n+2..n+1+NSTAT.
  - CRC word at n+2+NSTAT.
- Sampling points: L1A and STATUS are sampled on the edge that enters TR_L1A.
- The CRC word includes payload emitted up to the cycle before TR_L1A.
- BUSY is high from the cycle after acceptance through the CRC word.
- RST mid-operation:
  - Returns immediately to the reset values.
  - Drops pending END, CRC and OVERLAP.
  - No partial trailer is emitted after release.

## Test plan
- Reset: hold RST, toggle all inputs -> OUT, OUT_VLD, OUT_LAST, OVERLAP, BUSY all 0. After release, first ADC_VLD is served normally.
- Serialisation (defaults): ADC channels k = {k+1, 8'h01}, ADC_VLD at edge n -> OUT 0x0101, 0x0201, ... 0x0601 at edges n+1..n+6, OUT_VLD high exactly 6 cycles.
- Trailer: after the set above, END_REQ with L1A=0x15, STATUS=0xDEAD56 -> words 0xC015, 0xAD56, 0x837A, then CRC word with OUT_LAST=1, BUSY low the next cycle.
- Overlap:
  - Second ADC_VLD two cycles into SHIFT -> that set is dropped, OVERLAP high.
  - The following accepted set shows bit 15 = 1 on its sample words.
  - OVERLAP clears after the CRC word.
- Data-load CRC:
  - DLOAD with DATA=0x0000 for 18 cycles, then END_REQ -> CRC word 0x0000.
  - Single DLOAD word 0x0001, then END_REQ -> CRC word 0x8005.
- Reset mid-shift: RST at channel 3 with END pending -> outputs 0 at once. After release, END_REQ alone yields a trailer with CRC 0x0000.

Source files
------------

// File: rtl/adc_readout_mux.sv
// ----------------------------------------------------------------------------
// adc_readout_mux
//
// Serialises one parallel set of NADC ADC samples per capture strobe onto a
// single output bus, one word per clock. It accumulates a CRC-16 over the
// payload words and, on request, appends a trailer made of an L1A word,
// NSTAT status words and a CRC word. Sample sets that arrive while the
// serialiser is busy are dropped and flagged by a sticky overlap bit. While
// idle, a data-load mode passes words straight through and into the CRC.
//
// Ports
//   clk25ns  : single 25 ns clock; all logic on the rising edge
//   rst      : asynchronous, active-high reset
//   adc_vld  : one-cycle capture strobe for the adc bus
//   adc      : NADC packed samples, channel 0 in bits [ADC_W-1:0]
//   end_req  : one-cycle strobe requesting the trailer
//   dload    : data-load qualifier (honoured in IDLE only)
//   data     : data-load word
//   l1a      : L1A number, sampled on the edge that enters the trailer
//   status   : status vector, sampled on the edge that enters the trailer
//   out      : output word, 0 whenever out_vld is low
//   out_vld  : out carries a word
//   out_last : high with the CRC word only
//   overlap  : sticky overlap flag, cleared with the CRC word
//   busy     : a set or trailer is in progress
// ----------------------------------------------------------------------------
module adc_readout_mux #(
  parameter int NADC   = 6,
  parameter int ADC_W  = 13,
  parameter int OUT_W  = 16,
  parameter int L1A_W  = 6,
  parameter int STAT_W = 24
) (
  input  logic                  clk25ns,
  input  logic                  rst,
  input  logic                  adc_vld,
  input  logic [NADC*ADC_W-1:0] adc,
  input  logic                  end_req,
  input  logic                  dload,
  input  logic [OUT_W-1:0]      data,
  input  logic [L1A_W-1:0]      l1a,
  input  logic [STAT_W-1:0]     status,
  output logic [OUT_W-1:0]      out,
  output logic                  out_vld,
  output logic                  out_last,
  output logic                  overlap,
  output logic                  busy
);

  // Each status word carries a 2-bit tag, leaving CHUNK_W bits of payload.
  localparam int CHUNK_W    = OUT_W - 2;
  localparam int NSTAT      = (STAT_W + CHUNK_W - 1) / CHUNK_W;
  localparam int STAT_PAD_W = NSTAT * CHUNK_W;
  // One counter walks the channels in SHIFT and the chunks in TR_STAT.
  localparam int CNT_MAX    = (NADC > NSTAT) ? NADC : NSTAT;
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] LAST_CH   = CNT_W'(NADC - 1);
  localparam logic [CNT_W-1:0] LAST_STAT = CNT_W'(NSTAT - 1);
  localparam logic [15:0]      CRC_POLY  = 16'h8005;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_TR_L1A,
    S_TR_STAT,
    S_TR_CRC
  } state_t;

  state_t                  state, state_nxt;
  logic [NADC*ADC_W-1:0]   samp_q, samp_nxt;
  logic [STAT_PAD_W-1:0]   stat_q, stat_nxt;
  logic [L1A_W-1:0]        l1a_q, l1a_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [15:0]             crc, crc_nxt;
  logic                    end_pend, end_pend_nxt;
  logic [OUT_W-1:0]        out_nxt;
  logic                    out_vld_nxt, out_last_nxt, overlap_nxt, busy_nxt;
  logic                    last_ch, last_stat, accept, drop;

  // Folds one output word into the CRC, MSB first, polynomial 0x8005.
  function automatic logic [15:0] crc_fold(input logic [15:0] c,
                                           input logic [OUT_W-1:0] w);
    logic [15:0] r;
    logic        fb;
    // NOTE: blocking assignments here are intentional; each bit step must
    // see the previous one within the same evaluation.
    r = c;
    for (int i = OUT_W - 1; i >= 0; i--) begin
      fb = r[15] ^ w[i];
      r  = {r[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return r;
  endfunction

  assign last_ch   = (cnt == LAST_CH);
  assign last_stat = (cnt == LAST_STAT);

  // A set is taken in IDLE, or back-to-back on the last sample word unless a
  // trailer is about to start; anything else is an overlap.
  assign accept = adc_vld &&
                  ((state == S_IDLE) ||
                   ((state == S_SHIFT) && last_ch && !end_pend && !end_req));
  assign drop   = adc_vld && !accept;

  // State register.
  always_ff @(posedge clk25ns or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first so that no path leaves it unassigned and infers a latch.
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (adc_vld)      state_nxt = S_SHIFT;
        else if (end_req) state_nxt = S_TR_L1A;
      end
      S_SHIFT: begin
        if (last_ch) begin
          if (end_pend || end_req) state_nxt = S_TR_L1A;
          else if (adc_vld)        state_nxt = S_SHIFT;
          else                     state_nxt = S_IDLE;
        end
      end
      S_TR_L1A:  state_nxt = S_TR_STAT;
      S_TR_STAT: if (last_stat) state_nxt = S_TR_CRC;
      S_TR_CRC:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    samp_nxt     = samp_q;
    stat_nxt     = stat_q;
    l1a_nxt      = l1a_q;
    cnt_nxt      = '0;
    crc_nxt      = crc;
    end_pend_nxt = end_pend;
    out_nxt      = '0;
    out_vld_nxt  = 1'b0;
    out_last_nxt = 1'b0;
    // A drop on the CRC cycle still sets the flag for the next event.
    overlap_nxt  = drop | (overlap & (state != S_TR_CRC));
    // Covers both the cycle after acceptance and the last emitted word.
    busy_nxt     = (state != S_IDLE) || (state_nxt != S_IDLE);

    if (accept) samp_nxt = adc;

    if (end_req && ((state == S_SHIFT) || ((state == S_IDLE) && adc_vld)))
      end_pend_nxt = 1'b1;

    if (state_nxt == S_TR_L1A) begin
      end_pend_nxt = 1'b0;
      l1a_nxt      = l1a;
      stat_nxt     = STAT_PAD_W'(status);
    end

    unique case (state)
      S_IDLE: begin
        if (dload && !adc_vld && !end_req) begin
          out_nxt     = data;
          out_vld_nxt = 1'b1;
          crc_nxt     = crc_fold(crc, data);
        end
      end
      S_SHIFT: begin
        // Bit OUT_W-1 mirrors the overlap flag as it will read with this word.
        out_nxt     = {overlap_nxt, (OUT_W - 1)'(samp_q[ADC_W-1:0])};
        out_vld_nxt = 1'b1;
        crc_nxt     = crc_fold(crc, out_nxt);
        if (!accept) samp_nxt = samp_q >> ADC_W;
        if (!last_ch) cnt_nxt = cnt + CNT_W'(1);
      end
      S_TR_L1A: begin
        out_nxt     = {2'b11, CHUNK_W'(l1a_q)};
        out_vld_nxt = 1'b1;
      end
      S_TR_STAT: begin
        out_nxt     = {2'b10, stat_q[CHUNK_W-1:0]};
        out_vld_nxt = 1'b1;
        stat_nxt    = stat_q >> CHUNK_W;
        if (!last_stat) cnt_nxt = cnt + CNT_W'(1);
      end
      S_TR_CRC: begin
        out_nxt      = OUT_W'(crc);
        out_vld_nxt  = 1'b1;
        out_last_nxt = 1'b1;
        crc_nxt      = '0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  // NOTE: the sample and status holding registers are reset along with the
  // control state; they are small and a defined value simplifies debug.
  always_ff @(posedge clk25ns or posedge rst) begin
    if (rst) begin
      samp_q   <= '0;
      stat_q   <= '0;
      l1a_q    <= '0;
      cnt      <= '0;
      crc      <= '0;
      end_pend <= 1'b0;
      out      <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      overlap  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register
      // updates from pre-edge values regardless of statement order.
      samp_q   <= samp_nxt;
      stat_q   <= stat_nxt;
      l1a_q    <= l1a_nxt;
      cnt      <= cnt_nxt;
      crc      <= crc_nxt;
      end_pend <= end_pend_nxt;
      out      <= out_nxt;
      out_vld  <= out_vld_nxt;
      out_last <= out_last_nxt;
      overlap  <= overlap_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_adc_readout_mux.sv
// ----------------------------------------------------------------------------
// tb_adc_readout_mux
//
// Self-checking bench for adc_readout_mux with default parameters. A
// transaction-level model (queues of pending sample and trailer words) runs
// alongside the DUT; every cycle the DUT outputs are compared with the model.
// Directed sequences add literal checks for the documented example values.
// ----------------------------------------------------------------------------
module tb_adc_readout_mux;
  timeunit 1ns;
  timeprecision 100ps;

  localparam int NADC    = 6;
  localparam int ADC_W   = 13;
  localparam int OUT_W   = 16;
  localparam int L1A_W   = 6;
  localparam int STAT_W  = 24;
  localparam int CHUNK_W = OUT_W - 2;
  localparam int NSTAT   = (STAT_W + CHUNK_W - 1) / CHUNK_W;

  logic                  clk25ns = 1'b0;
  logic                  rst;
  logic                  adc_vld, end_req, dload;
  logic [NADC*ADC_W-1:0] adc;
  logic [OUT_W-1:0]      data;
  logic [L1A_W-1:0]      l1a;
  logic [STAT_W-1:0]     status;
  logic [OUT_W-1:0]      out;
  logic                  out_vld, out_last, overlap, busy;

  int n_tests = 0;
  int n_fail  = 0;

  adc_readout_mux #(
    .NADC(NADC), .ADC_W(ADC_W), .OUT_W(OUT_W), .L1A_W(L1A_W), .STAT_W(STAT_W)
  ) dut (
    .clk25ns (clk25ns),
    .rst     (rst),
    .adc_vld (adc_vld),
    .adc     (adc),
    .end_req (end_req),
    .dload   (dload),
    .data    (data),
    .l1a     (l1a),
    .status  (status),
    .out     (out),
    .out_vld (out_vld),
    .out_last(out_last),
    .overlap (overlap),
    .busy    (busy)
  );

  always #12.5 clk25ns = ~clk25ns;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- model
  typedef struct {
    logic [OUT_W-1:0] word;
    bit               is_crc;
  } tr_item_t;

  logic [ADC_W-1:0] m_samples[$];
  tr_item_t         m_trailer[$];
  bit               m_endp, m_ovl;
  logic [15:0]      m_crc;
  logic [OUT_W-1:0] e_out;
  bit               e_vld, e_last, e_busy;

  // CRC as polynomial remainder: ((crc ^ word) * x^16) mod (x^16+x^15+x^2+1).
  function automatic logic [15:0] crc_fold(input logic [15:0] c, input logic [15:0] w);
    logic [31:0] r;
    r = {c ^ w, 16'h0000};
    for (int i = 31; i >= 16; i--)
      if (r[i]) r = r ^ ({15'b0, 17'h18005} << (i - 16));
    return r[15:0];
  endfunction

  task automatic model_reset();
    m_samples.delete();
    m_trailer.delete();
    m_endp = 0; m_ovl = 0; m_crc = '0;
    e_out = '0; e_vld = 0; e_last = 0; e_busy = 0;
  endtask

  task automatic load_set();
    for (int k = 0; k < NADC; k++) m_samples.push_back(adc[k*ADC_W +: ADC_W]);
  endtask

  task automatic start_trailer();
    tr_item_t                  it;
    logic [NSTAT*CHUNK_W-1:0]  padded;
    it.is_crc = 0;
    it.word = OUT_W'(l1a);
    it.word[OUT_W-1 -: 2] = 2'b11;
    m_trailer.push_back(it);
    padded = '0;
    padded[STAT_W-1:0] = status;
    for (int j = 0; j < NSTAT; j++) begin
      it.word = {2'b10, padded[j*CHUNK_W +: CHUNK_W]};
      m_trailer.push_back(it);
    end
    it.word = '0;
    it.is_crc = 1;
    m_trailer.push_back(it);
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit               idle, emit, drop, last_word;
    logic [OUT_W-1:0] w;
    logic [ADC_W-1:0] s;
    tr_item_t         it;
    idle = (m_samples.size() == 0) && (m_trailer.size() == 0);
    emit = 0; drop = 0; w = '0; e_last = 0;
    if (idle) begin
      if (adc_vld) begin
        load_set();
        if (end_req) m_endp = 1;
      end else if (end_req) begin
        start_trailer();
      end else if (dload) begin
        emit = 1; w = data; m_crc = crc_fold(m_crc, w);
      end
    end else if (m_samples.size() > 0) begin
      s = m_samples.pop_front();
      last_word = (m_samples.size() == 0);
      if (end_req) m_endp = 1;
      if (adc_vld) begin
        if (last_word && !m_endp) load_set();
        else drop = 1;
      end
      m_ovl = m_ovl | drop;
      emit = 1;
      w = OUT_W'(s);
      w[OUT_W-1] = m_ovl;
      m_crc = crc_fold(m_crc, w);
      if (last_word && m_endp) begin
        start_trailer();
        m_endp = 0;
      end
    end else begin
      it = m_trailer.pop_front();
      emit = 1;
      drop = adc_vld;
      if (it.is_crc) begin
        w = OUT_W'(m_crc); e_last = 1; m_crc = '0; m_ovl = drop;
      end else begin
        w = it.word; m_ovl = m_ovl | drop;
      end
    end
    e_out  = emit ? w : '0;
    e_vld  = emit;
    e_busy = !idle || !((m_samples.size() == 0) && (m_trailer.size() == 0));
  endtask

  // --------------------------------------------------------------- checks
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: update the model, pass the edge, compare #1 after it.
  task automatic step();
    if (rst) model_reset();
    else     model_step();
    @(posedge clk25ns);
    #1;
    check("out", 32'(out), 32'(e_out));
    check("out_vld", 32'(out_vld), 32'(e_vld));
    check("out_last", 32'(out_last), 32'(e_last));
    check("overlap", 32'(overlap), 32'(m_ovl));
    check("busy", 32'(busy), 32'(e_busy));
  endtask

  task automatic drive(input bit v, input bit e, input bit d, input logic [OUT_W-1:0] dat);
    adc_vld = v; end_req = e; dload = d; data = dat;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, '0);
      step();
    end
  endtask

  // END_REQ from IDLE and the whole trailer; leaves the CRC word on the bus.
  task automatic run_trailer();
    drive(0, 1, 0, '0);
    step();
    idle_steps(NSTAT + 2);
  endtask

  task automatic set_pattern();
    for (int k = 0; k < NADC; k++) adc[k*ADC_W +: ADC_W] = ADC_W'(((k + 1) << 8) | 1);
  endtask

  task automatic randomize_inputs();
    for (int k = 0; k < NADC; k++) adc[k*ADC_W +: ADC_W] = ADC_W'($urandom);
    l1a = L1A_W'($urandom);
    status = STAT_W'($urandom);
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    rst = 1'b1;
    drive(0, 0, 0, '0);
    adc = '0; l1a = '0; status = '0;
    model_reset();

    // Reset held while inputs toggle.
    @(posedge clk25ns); #1;
    for (int i = 0; i < 4; i++) begin
      randomize_inputs();
      drive(1'($urandom), 1'($urandom), 1'($urandom), OUT_W'($urandom));
      step();
    end
    rst = 1'b0;
    idle_steps(2);

    // Serialisation of the reference set.
    set_pattern();
    drive(1, 0, 0, '0);
    step();
    for (int k = 0; k < NADC; k++) begin
      drive(0, 0, 0, '0);
      step();
      check("ser_word", 32'(out), 32'(16'h0101 + 16'(k) * 16'h0100));
    end
    idle_steps(1);
    check("ser_vld_end", 32'(out_vld), 32'd0);

    // Trailer after that set.
    l1a = 6'h15;
    status = 24'hDEAD56;
    drive(0, 1, 0, '0);
    step();
    drive(0, 0, 0, '0);
    step(); check("tr_l1a", 32'(out), 32'h0000C015);
    step(); check("tr_stat0", 32'(out), 32'h0000AD56);
    step(); check("tr_stat1", 32'(out), 32'h0000837A);
    step(); check("tr_crc_last", 32'(out_last), 32'd1);
    step(); check("tr_busy_after", 32'(busy), 32'd0);

    // Overlap: second strobe two cycles into SHIFT.
    set_pattern();
    drive(1, 0, 0, '0); step();
    drive(0, 0, 0, '0); step();
    drive(0, 0, 0, '0); step();
    drive(1, 0, 0, '0); step();
    check("ovl_set", 32'(overlap), 32'd1);
    idle_steps(NADC - 2);
    drive(1, 0, 0, '0); step();
    drive(0, 0, 0, '0); step();
    check("ovl_bit15", 32'(out[OUT_W-1]), 32'd1);
    idle_steps(NADC - 1);
    check("ovl_held", 32'(overlap), 32'd1);
    run_trailer();
    idle_steps(1);
    check("ovl_cleared", 32'(overlap), 32'd0);

    // Data-load CRC: zeros, then a single 0x0001.
    for (int i = 0; i < 18; i++) begin
      drive(0, 0, 1, 16'h0000);
      step();
    end
    run_trailer();
    check("dl_crc_zero", 32'(out), 32'h0);
    check("dl_crc_zero_last", 32'(out_last), 32'd1);
    drive(0, 0, 1, 16'h0001);
    step();
    run_trailer();
    check("dl_crc_8005", 32'(out), 32'h8005);

    // Reset mid-shift with END pending.
    randomize_inputs();
    drive(1, 1, 0, '0);
    step();
    idle_steps(4);
    #5;
    rst = 1'b1;
    #1;
    check("rst_out", 32'(out), 32'd0);
    check("rst_vld", 32'(out_vld), 32'd0);
    check("rst_ovl", 32'(overlap), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    model_reset();
    step();
    rst = 1'b0;
    idle_steps(2);
    run_trailer();
    check("rst_crc_zero", 32'(out), 32'h0);
    check("rst_crc_last", 32'(out_last), 32'd1);

    // Randomised traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
            1'($urandom), OUT_W'($urandom));
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end
    idle_steps(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
